// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: sequential byte fetcher feeding a circular decode queue
module inst_prefetch_queue #(
  parameter int QDEPTH = 16,
  parameter int AW = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AW-1:0]             reset_pc,
  output logic                      mem_req,
  output logic [AW-1:0]             mem_addr,
  input  logic                      mem_ack,
  input  logic [7:0]                mem_rdata,
  input  logic                      flush,
  input  logic [AW-1:0]             flush_pc,
  input  logic                      pop,
  input  logic [1:0]                pop_len,
  output logic [7:0]                q_byte0,
  output logic [7:0]                q_byte1,
  output logic [7:0]                q_byte2,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic [AW-1:0]             head_pc
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
  state_t state, state_n;
  logic [7:0] q [QDEPTH];
  logic [PW-1:0] head, tail;
  logic [AW-1:0] fetch_addr, fa_n;
  logic [CW-1:0] cnt_n, pl;
  logic push, pop_ok;
  assign pop_ok = pop && pop_len != 2'd0 && CW'(pop_len) <= q_count;
  assign pl = pop_ok ? CW'(pop_len) : '0;
  assign push = state == REQ && mem_ack && !flush;
  assign cnt_n = flush ? '0 : q_count + CW'(push) - pl;
  assign fa_n = flush ? flush_pc : fetch_addr + AW'(push);
  // DISCARD keeps the stale request on the bus until it completes
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = (flush || q_count < FULL) ? REQ : IDLE;
    else if (state == REQ) state_n = mem_ack ? ((flush || cnt_n < FULL) ? REQ : IDLE) : (flush ? DISCARD : REQ);
    else state_n = mem_ack ? REQ : DISCARD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mem_req <= 1'b0;
      head <= '0;
      tail <= '0;
      q_count <= '0;
      fetch_addr <= reset_pc;
      mem_addr <= reset_pc;
      head_pc <= reset_pc;
    end else begin
      state <= state_n;
      mem_req <= state_n != IDLE;
      q_count <= cnt_n;
      fetch_addr <= fa_n;
      if (state == IDLE || mem_ack) mem_addr <= fa_n;
      head <= flush ? '0 : head + pl[PW-1:0];
      tail <= flush ? '0 : tail + PW'(push);
      head_pc <= flush ? flush_pc : head_pc + AW'(pl);
    end
  end
  always_ff @(posedge clk) if (push && !rst) q[tail] <= mem_rdata;
  assign q_byte0 = q[head];
  assign q_byte1 = q[head + PW'(1)];
  assign q_byte2 = q[head + PW'(2)];
endmodule
